// File: rtl/ebr_march_driver_if.sv
// Pin bundle between the march driver and one DP8KC EBR port.
// master drives address/data/enables, slave (the EBR) returns DO.
interface ebr_march_driver_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] AD;
    logic [DATA_WIDTH-1:0] DI;
    logic                  WE;
    logic                  CE;
    logic                  OCE;
    logic [2:0]            CS;
    logic [DATA_WIDTH-1:0] DO;

    modport master (output AD, DI, WE, CE, OCE, CS, input DO);
    modport slave  (input AD, DI, WE, CE, OCE, CS, output DO);
endinterface

// File: rtl/ebr_march_driver.sv
// Full-depth write pass then read/compare pass over one DP8KC EBR port.
// Run takes 2*2^ADDR_WIDTH + READ_LATENCY + 1 cycles from START acceptance to DONE.
// No backpressure: the EBR is assumed to accept one access per cycle.
module ebr_march_driver #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    DATA_WIDTH   = 9,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN      = DATA_WIDTH'(9'h155)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    ebr_march_driver_if.master    ebr,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [15:0]           ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]            DRAIN_LAST = 3'(READ_LATENCY - 1);

    logic [2:0]            state;
    logic [2:0]            drain_cnt;
    logic [ADDR_WIDTH-1:0] ad_q;
    logic [ADDR_WIDTH-1:0] ad_inc;
    logic [DATA_WIDTH-1:0] di_q;
    logic                  we_q;
    logic                  ce_q;
    logic                  oce_q;

    logic                  exp_vld  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] exp_addr [READ_LATENCY];
    logic [DATA_WIDTH-1:0] exp_dat  [READ_LATENCY];

    logic                  mismatch;
    logic [15:0]           err_nxt;

    // Address zero-extended or truncated to the data width, then masked.
    function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d[i] = (i < ADDR_WIDTH) ? a[i % ADDR_WIDTH] : 1'b0;
        end
        return d ^ PATTERN;
    endfunction

    assign ad_inc  = ad_q + 1'b1;
    assign ebr.AD  = ad_q;
    assign ebr.DI  = di_q;
    assign ebr.WE  = we_q;
    assign ebr.CE  = ce_q;
    assign ebr.OCE = oce_q;
    assign ebr.CS  = 3'b000;

    always_comb begin
        mismatch = exp_vld[READ_LATENCY-1] && (ebr.DO != exp_dat[READ_LATENCY-1]);
        err_nxt  = ERR_COUNT;
        if (mismatch && (ERR_COUNT != 16'hFFFF)) begin
            err_nxt = ERR_COUNT + 16'd1;
        end
    end

    // Stage 0 captures the address on the pins this cycle, so the last stage
    // lines up with DO exactly READ_LATENCY cycles after the address was driven.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                exp_vld[i]  <= 1'b0;
                exp_addr[i] <= '0;
                exp_dat[i]  <= '0;
            end
        end else begin
            exp_vld[0]  <= (state == S_READ);
            exp_addr[0] <= ad_q;
            exp_dat[0]  <= pattern_of(ad_q);
            for (int i = 1; i < READ_LATENCY; i++) begin
                exp_vld[i]  <= exp_vld[i-1];
                exp_addr[i] <= exp_addr[i-1];
                exp_dat[i]  <= exp_dat[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            drain_cnt      <= '0;
            ad_q           <= '0;
            di_q           <= '0;
            we_q           <= 1'b0;
            ce_q           <= 1'b0;
            oce_q          <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
        end else begin
            DONE <= 1'b0;
            if (mismatch) begin
                ERR_COUNT <= err_nxt;
                if (ERR_COUNT == 16'd0) begin
                    FIRST_ERR_ADDR <= exp_addr[READ_LATENCY-1];
                end
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state          <= S_WRITE;
                        ad_q           <= '0;
                        di_q           <= PATTERN;
                        we_q           <= 1'b1;
                        ce_q           <= 1'b1;
                        oce_q          <= 1'b0;
                        BUSY           <= 1'b1;
                        PASS           <= 1'b0;
                        ERR_COUNT      <= '0;
                        FIRST_ERR_ADDR <= '0;
                    end
                end
                S_WRITE: begin
                    if (ad_q == LAST_ADDR) begin
                        state <= S_READ;
                        ad_q  <= '0;
                        di_q  <= '0;
                        we_q  <= 1'b0;
                        oce_q <= 1'b1;
                    end else begin
                        ad_q <= ad_inc;
                        di_q <= pattern_of(ad_inc);
                    end
                end
                S_READ: begin
                    if (ad_q == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        ad_q <= ad_inc;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                        ce_q  <= 1'b0;
                        oce_q <= 1'b0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (err_nxt == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebr_march_driver.sv
// Bench for ebr_march_driver: two instances (READ_LATENCY 1 and 2) on behavioural
// EBR models, checked against a run-schedule scoreboard.
module tb_ebr_march_driver;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        start     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [15:0] err       [2];
    logic [3:0]  ferr      [2];
    logic [3:0]  ad        [2];
    logic [8:0]  di        [2];
    logic        we        [2];
    logic        ce        [2];
    logic        oce       [2];
    logic [2:0]  cs        [2];
    logic [8:0]  q_dat     [2];
    logic        regmode   [2];
    logic        zero_mode [2];
    logic [15:0] flt_mask  [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        ebr_march_driver_if #(.ADDR_WIDTH(4), .DATA_WIDTH(9)) ebr ();

        ebr_march_driver #(
            .ADDR_WIDTH(4), .DATA_WIDTH(9), .READ_LATENCY(g + 1), .PATTERN(9'h155)
        ) u_dut (
            .CLK(clk), .RST(rst), .START(start[g]), .ebr(ebr),
            .BUSY(busy[g]), .DONE(done[g]), .PASS(pass[g]),
            .ERR_COUNT(err[g]), .FIRST_ERR_ADDR(ferr[g])
        );

        logic [8:0] mem [16];
        logic [8:0] raw;
        logic [8:0] oreg;

        // EBR model: synchronous array read, optional output register behind OCE,
        // and per-address bit0 fault injection on reads.
        always @(posedge clk) begin
            if (rst) begin
                raw  <= '0;
                oreg <= '0;
            end else begin
                if (ce[g]) begin
                    if (we[g]) mem[ad[g]] <= di[g];
                    else       raw <= mem[ad[g]] ^ {8'h00, flt_mask[g][ad[g]]};
                end
                if (oce[g]) oreg <= raw;
            end
        end

        assign ebr.DO   = zero_mode[g] ? 9'h000 : (regmode[g] ? oreg : raw);
        assign q_dat[g] = ebr.DO;
        assign ad[g]    = ebr.AD;
        assign di[g]    = ebr.DI;
        assign we[g]    = ebr.WE;
        assign ce[g]    = ebr.CE;
        assign oce[g]   = ebr.OCE;
        assign cs[g]    = ebr.CS;
    end

    function automatic logic [8:0] ref_data(input int a);
        return 9'(a % N) ^ 9'h155;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int s, input string tag);
        logic [63:0] v;
        v = {22'd0, ad[s], di[s], we[s], ce[s], oce[s], cs[s],
             busy[s], done[s], pass[s], err[s], ferr[s]};
        check_eq(tag, v, 64'd0);
    endtask

    // Starts a run on instance s from IDLE and follows it cycle by cycle against
    // the expected schedule: cycle k counts from the first cycle after acceptance.
    task automatic do_run(input int s, input bit ign, input int rst_at);
        int rl, exp_err, exp_first, bad, done_k, ndone, ign_w, last_k;
        rl        = s + 1;
        exp_err   = 0;
        exp_first = 0;
        bad       = 0;
        done_k    = -1;
        ndone     = 0;
        ign_w     = $urandom_range(0, N - 1);
        last_k    = 2 * N + rl + 2;
        start[s]  = 1'b1;
        @(negedge clk);
        start[s]  = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (k == rst_at) begin
                check_eq("rst_at_addr", ad[s], 64'(4'(k - N)));
                rst      = 1'b1;
                start[s] = 1'b0;
                @(negedge clk);
                check_zero(0, "rst_mid_u0");
                check_zero(1, "rst_mid_u1");
                rst = 1'b0;
                return;
            end
            if (k < N) begin
                if (ad[s] != 4'(k) || di[s] != ref_data(k) || !we[s] || !ce[s]) bad++;
            end else if (k < 2 * N) begin
                if (ad[s] != 4'(k - N) || di[s] != 9'h0 || we[s] || !ce[s] || !oce[s]) bad++;
            end else if (k < 2 * N + rl) begin
                if (ad[s] != 4'(N - 1) || we[s] || !ce[s] || !oce[s]) bad++;
            end
            if ((k < 2 * N + rl) != busy[s]) bad++;
            if (k >= N + rl && k < 2 * N + rl) begin
                if (q_dat[s] != ref_data(k - N - rl)) begin
                    if (exp_err == 0) exp_first = k - N - rl;
                    exp_err++;
                end
            end
            if (done[s]) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    check_eq("done_err", err[s], 64'(exp_err));
                    check_eq("done_first", ferr[s], 64'(exp_first));
                    check_eq("done_pass", pass[s], 64'(exp_err == 0));
                end
            end
            start[s] = ign && (k == ign_w || k == 2 * N + rl - 1);
            @(negedge clk);
        end
        check_eq("latency", 64'(done_k + 1), 64'(2 * N + rl + 1));
        check_eq("done_pulses", 64'(ndone), 64'd1);
        check_eq("pin_sequence", 64'(bad), 64'd0);
        check_eq("pass_hold", pass[s], 64'(exp_err == 0));
    endtask

    task automatic held(input int s);
        int rl, d1, d2, idle;
        rl   = s + 1;
        d1   = -1;
        d2   = -1;
        idle = 0;
        start[s] = 1'b1;
        for (int k = 0; k < 3 * (2 * N + rl + 2) && d2 < 0; k++) begin
            @(negedge clk);
            if (done[s]) begin
                if (d1 < 0) d1 = k;
                else        d2 = k;
            end else if (d1 >= 0 && !busy[s]) begin
                idle++;
            end
        end
        start[s] = 1'b0;
        check_eq("b2b_period", 64'(d2 - d1), 64'(2 * N + rl + 2));
        check_eq("b2b_idle", 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("b2b_stop", busy[s], 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst          = 1'b1;
        start        = '{1'b0, 1'b0};
        regmode      = '{1'b0, 1'b1};
        zero_mode    = '{1'b0, 1'b0};
        flt_mask     = '{16'h0, 16'h0};
        repeat (3) @(negedge clk);
        check_zero(0, "reset_u0");
        check_zero(1, "reset_u1");
        rst = 1'b0;
        @(negedge clk);

        // Ideal EBR, both latencies.
        do_run(0, 1'b0, -1);
        check_eq("t1_pass", pass[0], 64'd1);
        do_run(1, 1'b0, -1);
        check_eq("t2_pass", pass[1], 64'd1);

        // Output-registered EBR read with latency 1: every compare is one address behind.
        regmode[0] = 1'b1;
        do_run(0, 1'b0, -1);
        check_eq("t2_mis_pass", pass[0], 64'd0);
        check_eq("t2_mis_atleast15", 64'(err[0] >= 16'd15), 64'd1);
        regmode[0] = 1'b0;

        // Bit0 faults at 5 and 9, then a clean run clears the result.
        flt_mask[0] = 16'h0220;
        do_run(0, 1'b0, -1);
        check_eq("t3_err", err[0], 64'd2);
        check_eq("t3_first", ferr[0], 64'd5);
        check_eq("t3_pass", pass[0], 64'd0);
        flt_mask[0] = 16'h0;
        do_run(0, 1'b0, -1);
        check_eq("t3_clean_err", err[0], 64'd0);
        check_eq("t3_clean_pass", pass[0], 64'd1);

        // Reset while reading address 7, then a full clean run.
        do_run(0, 1'b0, N + 7);
        do_run(0, 1'b0, -1);
        check_eq("t4_pass", pass[0], 64'd1);

        // START ignored while busy; START held gives back-to-back runs.
        do_run(0, 1'b1, -1);
        do_run(1, 1'b1, -1);
        held(0);
        held(1);

        // Constant-zero read data: every address mismatches.
        zero_mode[0] = 1'b1;
        do_run(0, 1'b0, -1);
        check_eq("t6_err", err[0], 64'd16);
        check_eq("t6_first", ferr[0], 64'd0);
        check_eq("t6_pass", pass[0], 64'd0);
        zero_mode[0] = 1'b0;

        // Random sparse fault maps on random instances.
        for (int it = 0; it < 10; it++) begin
            s = $urandom_range(0, 1);
            flt_mask[s] = 16'($urandom & $urandom & $urandom);
            do_run(s, 1'($urandom_range(0, 1)), -1);
            flt_mask[s] = 16'h0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
